// File: rtl/correlator_pkg.sv
// Shared constants and helpers for the correlator chain: default geometry,
// pair-table extraction and the 1-bit sign-agreement counter.
package correlator_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_IBITS = 2;
  localparam int DEF_TRATE = 5;
  localparam int DEF_TBITS = 3;
  localparam int DEF_VBITS = 6;
  localparam logic [19:0] DEF_PAIRS = 20'h76321;

  // Upper bounds for the generic pair-table helpers.
  localparam int PAIRS_MAXW = 256;
  localparam int ENTRY_MAXW = 16;

  function automatic logic [ENTRY_MAXW-1:0] pair_entry(
    input logic [PAIRS_MAXW-1:0] pairs,
    input int                    slot,
    input int                    ibits
  );
    logic [ENTRY_MAXW-1:0] mask;
    mask = ENTRY_MAXW'((32'd1 << (2 * ibits)) - 32'd1);
    return ENTRY_MAXW'(pairs >> (slot * 2 * ibits)) & mask;
  endfunction

  function automatic logic [ENTRY_MAXW-1:0] pair_ant_a(
    input logic [ENTRY_MAXW-1:0] entry,
    input int                    ibits
  );
    return entry >> ibits;
  endfunction

  function automatic logic [ENTRY_MAXW-1:0] pair_ant_b(
    input logic [ENTRY_MAXW-1:0] entry,
    input int                    ibits
  );
    return entry & ENTRY_MAXW'((32'd1 << ibits) - 32'd1);
  endfunction

  // Number of agreeing sign pairs, 0..2.
  function automatic logic [1:0] xnor_count2(
    input logic a0,
    input logic b0,
    input logic a1,
    input logic b1
  );
    return {1'b0, a0 ~^ b0} + {1'b0, a1 ~^ b1};
  endfunction

endpackage

// File: rtl/pair_product.sv
// Stage 1 of the correlator: per-slot antenna pair select and the 1-bit
// complex product A*conj(B) expressed as real/imag agreement counts.
module pair_product
  import correlator_pkg::*;
#(
  parameter int                         WIDTH = DEF_WIDTH,
  parameter int                         IBITS = DEF_IBITS,
  parameter int                         TRATE = DEF_TRATE,
  parameter int                         TBITS = DEF_TBITS,
  parameter logic [TRATE*2*IBITS-1:0]   PAIRS = DEF_PAIRS
) (
  input  logic             vis_clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic [TBITS-1:0] taddr_i,
  input  logic [WIDTH-1:0] idata_i,
  input  logic [WIDTH-1:0] qdata_i,
  output logic             vld_o,
  output logic             first_o,
  output logic             last_o,
  output logic [TBITS-1:0] taddr_o,
  output logic [1:0]       dre_o,
  output logic [1:0]       dim_o
);

  logic [IBITS-1:0] ant_a, ant_b;
  logic             ai, aq, bi, bq;
  logic             in_range;
  logic [1:0]       dre_d, dim_d;

  logic             vld_p1_q;
  logic             first_p1_q, last_p1_q;
  logic [TBITS-1:0] taddr_p1_q;
  logic [1:0]       dre_p1_q, dim_p1_q;

  always_comb begin
    ant_a    = IBITS'(pair_ant_a(pair_entry(PAIRS_MAXW'(PAIRS), int'(taddr_i), IBITS), IBITS));
    ant_b    = IBITS'(pair_ant_b(pair_entry(PAIRS_MAXW'(PAIRS), int'(taddr_i), IBITS), IBITS));
    ai       = idata_i[ant_a];
    aq       = qdata_i[ant_a];
    bi       = idata_i[ant_b];
    bq       = qdata_i[ant_b];
    in_range = ({1'b0, taddr_i} < (TBITS+1)'(TRATE));
    dre_d    = xnor_count2(ai, bi, aq, bq);
    // ai XOR bq is the same as ai XNOR ~bq.
    dim_d    = xnor_count2(aq, bi, ai, ~bq);
  end

  // ---- stage 1 register (p1) ----
  always_ff @(posedge vis_clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= valid_i && in_range;
    end
  end

  always_ff @(posedge vis_clk) begin
    if (valid_i) begin
      first_p1_q <= first_i;
      last_p1_q  <= last_i;
      taddr_p1_q <= taddr_i;
      dre_p1_q   <= dre_d;
      dim_p1_q   <= dim_d;
    end
  end

  assign vld_o   = vld_p1_q;
  assign first_o = first_p1_q;
  assign last_o  = last_p1_q;
  assign taddr_o = taddr_p1_q;
  assign dre_o   = dre_p1_q;
  assign dim_o   = dim_p1_q;

endmodule

// File: rtl/pairwise_correlator.sv
// Per-slot 1-bit visibility accumulator: pair product, saturating per-slot
// register file with single-cycle read-modify-write, and framed output.
module pairwise_correlator
  import correlator_pkg::*;
#(
  parameter int                       WIDTH = DEF_WIDTH,
  parameter int                       IBITS = DEF_IBITS,
  parameter int                       TRATE = DEF_TRATE,
  parameter int                       TBITS = DEF_TBITS,
  parameter int                       VBITS = DEF_VBITS,
  parameter logic [TRATE*2*IBITS-1:0] PAIRS = DEF_PAIRS
) (
  input  logic             vis_clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic [TBITS-1:0] taddr_i,
  input  logic [WIDTH-1:0] idata_i,
  input  logic [WIDTH-1:0] qdata_i,
  output logic             valid_o,
  output logic [TBITS-1:0] taddr_o,
  output logic [VBITS-1:0] re_o,
  output logic [VBITS-1:0] im_o,
  output logic             sat_o
);

  // Returns {overflow, clamped sum}.
  function automatic logic [VBITS:0] sat_add(
    input logic [VBITS-1:0] acc,
    input logic [1:0]       d
  );
    logic [VBITS:0] sum;
    sum = {1'b0, acc} + (VBITS+1)'(d);
    if (sum[VBITS]) begin
      return {1'b1, {VBITS{1'b1}}};
    end
    return sum;
  endfunction

  logic             vld_p1, first_p1, last_p1;
  logic [TBITS-1:0] taddr_p1;
  logic [1:0]       dre_p1, dim_p1;

  pair_product #(
    .WIDTH (WIDTH),
    .IBITS (IBITS),
    .TRATE (TRATE),
    .TBITS (TBITS),
    .PAIRS (PAIRS)
  ) u_pair_product (
    .vis_clk (vis_clk),
    .reset   (reset),
    .valid_i (valid_i),
    .first_i (first_i),
    .last_i  (last_i),
    .taddr_i (taddr_i),
    .idata_i (idata_i),
    .qdata_i (qdata_i),
    .vld_o   (vld_p1),
    .first_o (first_p1),
    .last_o  (last_p1),
    .taddr_o (taddr_p1),
    .dre_o   (dre_p1),
    .dim_o   (dim_p1)
  );

  logic [VBITS-1:0] acc_re_q [TRATE];
  logic [VBITS-1:0] acc_im_q [TRATE];
  logic [VBITS-1:0] base_re, base_im;
  logic [VBITS-1:0] upd_re_d, upd_im_d;
  logic             ovf_re, ovf_im;

  logic             valid_q;
  logic [TBITS-1:0] taddr_q;
  logic [VBITS-1:0] re_q, im_q;
  logic             sat_q;

  always_comb begin
    base_re = first_p1 ? '0 : acc_re_q[taddr_p1];
    base_im = first_p1 ? '0 : acc_im_q[taddr_p1];
    {ovf_re, upd_re_d} = sat_add(base_re, dre_p1);
    {ovf_im, upd_im_d} = sat_add(base_im, dim_p1);
  end

  // ---- stage 2: accumulate and register the output (p2) ----
  always_ff @(posedge vis_clk) begin
    if (reset) begin
      for (int t = 0; t < TRATE; t++) begin
        acc_re_q[t] <= '0;
        acc_im_q[t] <= '0;
      end
      valid_q <= 1'b0;
      taddr_q <= '0;
      re_q    <= '0;
      im_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= vld_p1 && last_p1;
      if (vld_p1) begin
        acc_re_q[taddr_p1] <= upd_re_d;
        acc_im_q[taddr_p1] <= upd_im_d;
        sat_q              <= sat_q | ovf_re | ovf_im;
        if (last_p1) begin
          taddr_q <= taddr_p1;
          re_q    <= upd_re_d;
          im_q    <= upd_im_d;
        end
      end
    end
  end

  assign valid_o = valid_q;
  assign taddr_o = taddr_q;
  assign re_o    = re_q;
  assign im_o    = im_q;
  assign sat_o   = sat_q;

endmodule
